// File: rtl/hdr_seq_ctrl_pkg.sv
// Shared definitions for the header sequencer: state encodings, unit indices,
// default buffer offsets and the enabled-unit search helper.
package hdr_seq_ctrl_pkg;

    localparam int NUM_UNITS = 3;

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_START = 4'b0010;
    localparam logic [3:0] ST_WAIT  = 4'b0100;
    localparam logic [3:0] ST_DONE  = 4'b1000;

    localparam logic [1:0] UNIT_ETH = 2'd0;
    localparam logic [1:0] UNIT_IP  = 2'd1;
    localparam logic [1:0] UNIT_UDP = 2'd2;

    localparam int DEF_BASE0 = 0;
    localparam int DEF_BASE1 = 14;
    localparam int DEF_BASE2 = 34;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } unit_sel_t;

    // Lowest enabled unit whose index is >= from; valid=0 when none remains.
    function automatic unit_sel_t next_unit(input logic [2:0] en, input logic [2:0] from);
        unit_sel_t sel;
        sel = '0;
        for (int k = NUM_UNITS - 1; k >= 0; k--) begin
            if (en[k] && (3'(k) >= from)) begin
                sel.valid = 1'b1;
                sel.idx   = 2'(k);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hdr_wr_mux.sv
// Registered header-buffer write mux: forwards only the active unit's writes,
// adds that unit's base offset, and flags writes from any other source.
module hdr_wr_mux
    import hdr_seq_ctrl_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int IDX_W  = 4,
    parameter int BASE0  = DEF_BASE0,
    parameter int BASE1  = DEF_BASE1,
    parameter int BASE2  = DEF_BASE2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [1:0]             i_cur,
    input  logic                   i_fwd_en,
    input  logic [3*IDX_W-1:0]     i_unit_idx,
    input  logic [23:0]            i_unit_byte,
    input  logic [2:0]             i_unit_wr,
    output logic [ADDR_W-1:0]      o_buf_addr,
    output logic [7:0]             o_buf_byte,
    output logic                   o_buf_wr,
    output logic                   o_stray
);

    logic [IDX_W-1:0]  idx_arr  [NUM_UNITS];
    logic [7:0]        byte_arr [NUM_UNITS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unpack
            assign idx_arr[gi]  = i_unit_idx[gi*IDX_W +: IDX_W];
            assign byte_arr[gi] = i_unit_byte[gi*8 +: 8];
        end
    endgenerate

    logic [2:0]        cur_mask;
    logic [IDX_W-1:0]  sel_idx;
    logic [ADDR_W-1:0] sel_base;
    logic              wr_d,   wr_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [7:0]        byte_d, byte_q;

    always_comb begin
        cur_mask = 3'b001 << i_cur;
        sel_idx  = '0;
        sel_base = '0;
        byte_d   = '0;
        case (i_cur)
            UNIT_ETH: begin sel_idx = idx_arr[0]; byte_d = byte_arr[0]; sel_base = ADDR_W'(BASE0); end
            UNIT_IP:  begin sel_idx = idx_arr[1]; byte_d = byte_arr[1]; sel_base = ADDR_W'(BASE1); end
            UNIT_UDP: begin sel_idx = idx_arr[2]; byte_d = byte_arr[2]; sel_base = ADDR_W'(BASE2); end
            default:  ;
        endcase
        // The sum wraps naturally at ADDR_W bits.
        addr_d  = sel_base + ADDR_W'(sel_idx);
        wr_d    = i_fwd_en & (|(i_unit_wr & cur_mask));
        o_stray = i_fwd_en ? (|(i_unit_wr & ~cur_mask)) : (|i_unit_wr);
    end

    // Address/data only move on a forwarded write so the bus stays quiet otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            byte_q <= '0;
        end else begin
            wr_q <= wr_d;
            if (wr_d) begin
                addr_q <= addr_d;
                byte_q <= byte_d;
            end
        end
    end

    assign o_buf_wr   = wr_q;
    assign o_buf_addr = addr_q;
    assign o_buf_byte = byte_q;

endmodule

// File: rtl/hdr_seq_ctrl.sv
// Header build sequencer: triggers each enabled writer unit in order, waits
// for its ready (with timeout), and owns the shared header buffer write port.
module hdr_seq_ctrl
    import hdr_seq_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int IDX_W   = 4,
    parameter int BASE0   = DEF_BASE0,
    parameter int BASE1   = DEF_BASE1,
    parameter int BASE2   = DEF_BASE2,
    parameter int TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [2:0]         i_unit_en,
    output logic [2:0]         o_unit_start,
    input  logic [2:0]         i_unit_ready,
    input  logic [3*IDX_W-1:0] i_unit_idx,
    input  logic [23:0]        i_unit_byte,
    input  logic [2:0]         i_unit_wr,
    output logic [ADDR_W-1:0]  o_buf_addr,
    output logic [7:0]         o_buf_byte,
    output logic               o_buf_wr,
    output logic               o_busy,
    output logic               o_done,
    output logic [1:0]         o_err
);

    logic [3:0] state_d, state_q;
    logic [1:0] cur_d,   cur_q;
    logic [2:0] en_d,    en_q;
    logic [7:0] cnt_d,   cnt_q;
    logic [1:0] err_d,   err_q;

    logic       fwd_en;
    logic       stray;
    logic [2:0] cur_mask;
    logic       cur_ready;
    unit_sel_t  first_sel;
    unit_sel_t  next_sel;

    assign fwd_en    = (state_q == ST_START) || (state_q == ST_WAIT);
    assign cur_mask  = 3'b001 << cur_q;
    assign cur_ready = |(i_unit_ready & cur_mask);
    assign first_sel = next_unit(i_unit_en, 3'd0);
    assign next_sel  = next_unit(en_q, {1'b0, cur_q} + 3'd1);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        en_d    = en_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    en_d  = i_unit_en;
                    err_d = 2'b00;
                    if (first_sel.valid) begin
                        cur_d   = first_sel.idx;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_START: begin
                cnt_d   = 8'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Ready is checked first so it wins over a coincident timeout.
                if (cur_ready) begin
                    if (next_sel.valid) begin
                        cur_d   = next_sel.idx;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    err_d[0] = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (stray) begin
            err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cur_q   <= 2'd0;
            en_q    <= 3'b000;
            cnt_q   <= 8'd0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    hdr_wr_mux #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W),
        .BASE0  (BASE0),
        .BASE1  (BASE1),
        .BASE2  (BASE2)
    ) u_wr_mux (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cur       (cur_q),
        .i_fwd_en    (fwd_en),
        .i_unit_idx  (i_unit_idx),
        .i_unit_byte (i_unit_byte),
        .i_unit_wr   (i_unit_wr),
        .o_buf_addr  (o_buf_addr),
        .o_buf_byte  (o_buf_byte),
        .o_buf_wr    (o_buf_wr),
        .o_stray     (stray)
    );

    assign o_unit_start = (state_q == ST_START) ? cur_mask : 3'b000;
    assign o_done       = (state_q == ST_DONE);
    assign o_busy       = (state_q != ST_IDLE);
    assign o_err        = err_q;

endmodule

// File: tb/tb_hdr_seq_ctrl.sv
// Self-checking bench for hdr_seq_ctrl: behavioural writer-unit models plus a
// cycle-level reference of starts, buffer writes, done timing and error flags.
module tb_hdr_seq_ctrl;

    localparam int T  = 8;
    localparam int AW = 6;

    int base_tab [3] = '{0, 14, 34};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [2:0]    i_unit_en = 3'b000;
    logic [2:0]    i_unit_ready = 3'b000;
    logic [2:0]    i_unit_wr = 3'b000;
    logic [11:0]   i_unit_idx = '0;
    logic [23:0]   i_unit_byte = '0;
    logic [2:0]    o_unit_start;
    logic [AW-1:0] o_buf_addr;
    logic [7:0]    o_buf_byte;
    logic          o_buf_wr;
    logic          o_busy;
    logic          o_done;
    logic [1:0]    o_err;

    hdr_seq_ctrl #(
        .ADDR_W (AW), .IDX_W (4), .BASE0 (0), .BASE1 (14), .BASE2 (34), .TIMEOUT (T)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_unit_en    (i_unit_en),
        .o_unit_start (o_unit_start),
        .i_unit_ready (i_unit_ready),
        .i_unit_idx   (i_unit_idx),
        .i_unit_byte  (i_unit_byte),
        .i_unit_wr    (i_unit_wr),
        .o_buf_addr   (o_buf_addr),
        .o_buf_byte   (o_buf_byte),
        .o_buf_wr     (o_buf_wr),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int unit;
        int addr;
        int data;
    } ev_t;

    ev_t start_log[$];
    ev_t wr_log[$];
    int  done_log[$];

    int  n_wr      [3] = '{6, 6, 6};
    bit  never_rdy [3] = '{0, 0, 0};
    int  idx_tab   [3][8];
    int  byte_tab  [3][8];
    int  ucnt      [3] = '{-1, -1, -1};
    int  stray_cyc  = -1;
    int  stray_unit = 0;

    int  n_checks = 0;
    int  n_fail   = 0;

    // Monitor, then writer-unit models: a unit writes n bytes starting the
    // cycle after its start pulse and pulses ready two cycles after the last.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++)
            if (o_unit_start[k]) start_log.push_back(ev_t'{cyc, k, 0, 0});
        if (o_buf_wr) wr_log.push_back(ev_t'{cyc, 0, int'(o_buf_addr), int'(o_buf_byte)});
        if (o_done) done_log.push_back(cyc);

        i_unit_wr    = 3'b000;
        i_unit_ready = 3'b000;
        i_unit_idx   = 12'($urandom);
        i_unit_byte  = 24'($urandom);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                ucnt[k] = -1;
            end else begin
                if (ucnt[k] >= 0) ucnt[k]++;
                if (ucnt[k] > 60) ucnt[k] = -1;
                if (o_unit_start[k]) ucnt[k] = 0;
                if (ucnt[k] >= 1 && ucnt[k] <= n_wr[k]) begin
                    i_unit_wr[k] = 1'b1;
                    i_unit_idx[k*4 +: 4]  = 4'(idx_tab[k][ucnt[k]-1]);
                    i_unit_byte[k*8 +: 8] = 8'(byte_tab[k][ucnt[k]-1]);
                end
                if (ucnt[k] == n_wr[k] + 2 && !never_rdy[k]) begin
                    i_unit_ready[k] = 1'b1;
                    ucnt[k] = -1;
                end
            end
        end
        if (rst_n && cyc == stray_cyc) i_unit_wr[stray_unit] = 1'b1;
    end

    task automatic clear_logs();
        start_log.delete();
        wr_log.delete();
        done_log.delete();
    endtask

    task automatic run_build(input string name, input logic [2:0] en, input bit seq_idx,
                             input int stray_off, input int restart_off);
        int        c0, s, exp_done, budget, nmin;
        logic [1:0] exp_err;
        bit        stopped;
        ev_t       es[$];
        ev_t       ew[$];
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 8; j++) begin
                byte_tab[k][j] = int'($urandom_range(0, 255));
                idx_tab[k][j]  = seq_idx ? j : int'($urandom_range(0, 15));
            end
        clear_logs();
        @(posedge clk); #2;
        c0 = cyc;
        i_unit_en = en;
        i_start   = 1'b1;
        stray_cyc = (stray_off >= 0) ? c0 + stray_off : -1;
        budget = 0;
        do begin
            @(posedge clk); #2;
            budget++;
            i_start = (restart_off > 0) && (cyc == c0 + restart_off);
            if (cyc == c0 + 1) i_unit_en = 3'($urandom);
        end while (done_log.size() == 0 && budget < 150);
        repeat (3) @(posedge clk);
        #2;
        i_start   = 1'b0;
        stray_cyc = -1;

        s = c0 + 1;
        exp_done = c0 + 1;
        exp_err = {(stray_off >= 0), 1'b0};
        stopped = 0;
        for (int k = 0; k < 3; k++) begin
            if (en[k] && !stopped) begin
                es.push_back(ev_t'{s, k, 0, 0});
                for (int j = 0; j < n_wr[k]; j++)
                    ew.push_back(ev_t'{s + 2 + j, 0, (base_tab[k] + idx_tab[k][j]) % 64, byte_tab[k][j]});
                if (never_rdy[k]) begin
                    exp_done = s + T + 1;
                    exp_err[0] = 1'b1;
                    stopped = 1;
                end else begin
                    s = s + n_wr[k] + 3;
                    exp_done = s;
                end
            end
        end

        n_checks++;
        if (done_log.size() !== 1) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d, expected 1", name, done_log.size());
        end
        if (done_log.size() > 0) begin
            n_checks++;
            if (done_log[0] !== exp_done) begin
                n_fail++;
                $display("FAIL %s done_cycle: got %0d, expected %0d", name, done_log[0] - c0, exp_done - c0);
            end
        end
        n_checks++;
        if (start_log.size() !== es.size()) begin
            n_fail++;
            $display("FAIL %s start_count: got %0d, expected %0d", name, start_log.size(), es.size());
        end
        nmin = (start_log.size() < es.size()) ? start_log.size() : es.size();
        for (int i = 0; i < nmin; i++) begin
            n_checks++;
            if (start_log[i].unit !== es[i].unit || start_log[i].cyc !== es[i].cyc) begin
                n_fail++;
                $display("FAIL %s start[%0d]: got unit %0d @%0d, expected unit %0d @%0d", name, i,
                         start_log[i].unit, start_log[i].cyc - c0, es[i].unit, es[i].cyc - c0);
            end
        end
        n_checks++;
        if (wr_log.size() !== ew.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d, expected %0d", name, wr_log.size(), ew.size());
        end
        nmin = (wr_log.size() < ew.size()) ? wr_log.size() : ew.size();
        for (int i = 0; i < nmin; i++) begin
            n_checks++;
            if (wr_log[i].cyc !== ew[i].cyc || wr_log[i].addr !== ew[i].addr || wr_log[i].data !== ew[i].data) begin
                n_fail++;
                $display("FAIL %s write[%0d]: got addr %0d data %02h @%0d, expected addr %0d data %02h @%0d",
                         name, i, wr_log[i].addr, wr_log[i].data, wr_log[i].cyc - c0,
                         ew[i].addr, ew[i].data, ew[i].cyc - c0);
            end
        end
        n_checks++;
        if (o_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s err: got %b, expected %b", name, o_err, exp_err);
        end
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_after: got %b, expected 0", name, o_busy);
        end
        $display("build %s: en=%b starts=%0d writes=%0d done@+%0d err=%b",
                 name, en, start_log.size(), wr_log.size(),
                 (done_log.size() > 0) ? done_log[0] - c0 : -1, o_err);
    endtask

    task automatic set_units(input int n0, input int n1, input int n2);
        n_wr[0] = n0; n_wr[1] = n1; n_wr[2] = n2;
        never_rdy[0] = 0; never_rdy[1] = 0; never_rdy[2] = 0;
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({o_unit_start, o_buf_addr, o_buf_byte, o_buf_wr, o_busy, o_done, o_err} !== '0) begin
            n_fail++;
            $display("FAIL %s outputs: got start=%b addr=%0d byte=%02h wr=%b busy=%b done=%b err=%b, expected all 0",
                     name, o_unit_start, o_buf_addr, o_buf_byte, o_buf_wr, o_busy, o_done, o_err);
        end
        $display("reset %s: outputs checked", name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("power_on");
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("after_release");
    endtask

    task automatic test_all_units();
        set_units(6, 6, 6);
        run_build("all_units", 3'b111, 1'b1, -1, 0);
    endtask

    task automatic test_single_unit();
        set_units(6, 6, 6);
        run_build("only_ip", 3'b010, 1'b1, -1, 0);
    endtask

    task automatic test_no_units();
        set_units(6, 6, 6);
        run_build("no_units", 3'b000, 1'b0, -1, 0);
    endtask

    task automatic test_timeout();
        set_units(4, 3, 5);
        never_rdy[1] = 1;
        run_build("timeout_ip", 3'b111, 1'b0, -1, 0);
        never_rdy[1] = 0;
    endtask

    task automatic test_stray();
        set_units(5, 4, 3);
        clear_logs();
        stray_unit = 0;
        @(posedge clk); #2;
        stray_cyc = cyc + 1;
        repeat (4) @(posedge clk);
        #2;
        stray_cyc = -1;
        n_checks++;
        if (wr_log.size() !== 0) begin
            n_fail++;
            $display("FAIL idle_stray writes: got %0d, expected 0", wr_log.size());
        end
        n_checks++;
        if (o_err !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_stray err: got %b, expected 10", o_err);
        end
        $display("stray idle: writes=%0d err=%b", wr_log.size(), o_err);
        stray_unit = 2;
        run_build("stray_during_eth", 3'b111, 1'b0, 3, 4);
    endtask

    task automatic test_reset_mid();
        int  budget;
        bit  seen;
        set_units(6, 6, 6);
        clear_logs();
        @(posedge clk); #2;
        i_unit_en = 3'b111;
        i_start = 1'b1;
        @(posedge clk); #2;
        i_start = 1'b0;
        seen = 0;
        budget = 0;
        while (!seen && budget < 100) begin
            @(posedge clk); #2;
            budget++;
            foreach (start_log[i]) if (start_log[i].unit == 1) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_mid ip_start: got none, expected unit 1 start");
        end
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_build");
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (done_log.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_mid done: got %0d pulses, expected 0", done_log.size());
        end
        rst_n = 1'b1;
        run_build("after_reset", 3'b111, 1'b0, -1, 0);
    endtask

    task automatic test_random();
        logic [2:0] en;
        for (int it = 0; it < 8; it++) begin
            set_units(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
            if ($urandom_range(0, 3) == 0) never_rdy[$urandom_range(0, 2)] = 1;
            en = 3'($urandom);
            run_build($sformatf("random_%0d", it), en, 1'b0, -1, 0);
        end
        set_units(6, 6, 6);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_all_units();
        test_single_unit();
        test_no_units();
        test_stray();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hdr_seq_ctrl.md
# hdr_seq_ctrl

Sequences the three header-field writer units (unit 0 Ethernet MAC writer, unit 1 IP header writer, unit 2 UDP header writer) that share one header buffer write port. On a start pulse it triggers each enabled unit in turn, waits for that unit's ready pulse, and muxes only the active unit's byte writes onto the buffer port, adding a per-unit base offset. It then pulses done toward the frame transmitter.

## Interface
- ADDR_W, 6, header buffer address width
- IDX_W, 4, width of each unit's local byte index
- BASE0, 0, buffer offset of unit 0 (Ethernet)
- BASE1, 14, buffer offset of unit 1 (IP)
- BASE2, 34, buffer offset of unit 2 (UDP)
- TIMEOUT, 255, max cycles spent waiting for one unit's ready (8-bit counter)

Ports:
- i_clk  in  1  clock; the block runs on this single clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  build request, sampled in IDLE only
- i_unit_en  in  3  per-unit enable, latched on accepted i_start
- o_unit_start  out  3  one-cycle trigger to unit k
- i_unit_ready  in  3  one-cycle completion pulse from unit k
- i_unit_idx  in  3*IDX_W  packed local indices, unit k at [k*IDX_W +: IDX_W]
- i_unit_byte  in  24  packed bytes, unit k at [8k +: 8]
- i_unit_wr  in  3  byte-write strobe from unit k
- o_buf_addr  out  ADDR_W  header buffer address
- o_buf_byte  out  8  header buffer data
- o_buf_wr  out  1  header buffer write enable
- o_busy  out  1  high whenever state is not IDLE
- o_done  out  1  one-cycle end-of-build pulse
- o_err  out  2  sticky flags: bit0 timeout, bit1 stray write

## Operation
- States are IDLE, START, WAIT and DONE. A 2-bit cur register selects the active unit; en_q holds the latched enables.
- IDLE, i_start=1:
  - latch en_q, clear o_err
  - cur = lowest enabled unit, go to START
  - if no unit is enabled, go straight to DONE
- START: o_unit_start[cur]=1 for this single cycle. Clear the timeout counter and go to WAIT.
- WAIT:
  - i_unit_ready[cur]=1: if a higher enabled unit exists, cur = next enabled unit and go to START; otherwise go to DONE.
  - timeout counter reaching TIMEOUT without ready: set o_err[0] and go to DONE (abort the remaining units).
  - ready and timeout in the same cycle: ready wins.
- DONE: o_done=1 for one cycle, then go to IDLE.
- Write mux:
  - o_buf_wr is the registered i_unit_wr[cur], qualified by state being START or WAIT.
  - o_buf_addr is the registered BASEcur + idx_cur, truncated modulo 2^ADDR_W.
  - o_buf_byte is the registered i_unit_byte[cur].
- Stray write: i_unit_wr[k]=1 with k≠cur, or any i_unit_wr while in IDLE/DONE. The write is dropped and o_err[1] is set.
- i_start while busy is ignored; no queuing.
- i_unit_ready from a non-current unit is ignored.
- o_unit_start and o_done are decoded from registered state and are glitch-free.

## Timing
- Reset values: all outputs 0; state IDLE; cur=0; en_q=0; counter=0.
- Reset asserted mid-build returns everything to reset values immediately. No done pulse is produced.
- i_start high at edge n: START at cycle n+1 (o_unit_start high), WAIT from n+2.
- Ready seen in cycle t: next START or DONE at t+1. A full 3-unit build costs 3×(2 + unit latency) + 1 cycles.
- Write latency is exactly one cycle from i_unit_wr to o_buf_wr.
- A unit's final write and its ready pulse may fall in consecutive cycles; the final write is still forwarded.
- o_err holds until the next accepted i_start.

## Structure
- Shared header package holds:
  - state encodings (one-hot localparams, 4 bits)
  - unit indices UNIT_ETH=0, UNIT_IP=1, UNIT_UDP=2
  - default base offsets 0/14/34
- One natural sub-module, hdr_wr_mux: the registered write mux with base-offset adder and stray-write detect. The FSM stays in hdr_seq_ctrl.

## Test plan
- All units enabled; each unit model writes 6 bytes then pulses ready 2 cycles later. Expect:
  - o_unit_start pulses for units 0, 1, 2 in order
  - writes land at addresses 0–5, 14–19 and 34–39
  - one o_done pulse; o_err=0
- i_unit_en=3'b010; i_start. Expect:
  - only o_unit_start[1]
  - writes at 14 onward
  - o_done 1 cycle after unit 1's ready
- i_unit_en=0; i_start at edge n. Expect o_done at n+1, no unit starts, no writes.
- Unit 1 never readies; TIMEOUT=8. Expect:
  - DONE 8 cycles into WAIT
  - o_err=2'b01
  - unit 2 is never started
- Unit 2 asserts i_unit_wr while unit 0 is active. Expect the write dropped (o_buf_wr stays 0 for it) and o_err[1]=1. Also i_start during WAIT is ignored.
- Reset pulsed during unit 1's WAIT. Expect all outputs 0 at once, no o_done; a fresh i_start then runs a clean build.
